des_key_sched_seq: RTL and testbench

Sequential DES key scheduler that expands a 64-bit key into the sixteen 48-bit round keys and streams them one per accepted handshake. It serves both directions: forward order K1..K16 for encryption, and reverse order K16..K1 for decryption, which the decrypt datapath needs. It sits between the key register and a single-round, iterative DES core, so the 16-key combinational expansion is not needed in that path.

---
 rtl/des_key_sched_seq.sv | 170 +++++++++++++++++
 tb/tb_des_key_sched_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched_seq.sv
// Sequential DES key schedule: PC-1 load, per-round C/D rotation, PC-2 output.
// Streams K1..K16 (encrypt) or K16..K1 (decrypt) over a valid/ready handshake.
module des_key_sched_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic        busy,
    output logic        rkey_valid,
    input  logic        rkey_ready,
    output logic [47:0] rkey,
    output logic [3:0]  rkey_idx,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_FIN
    } state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Bit r set when round r+1 rotates by one; all other rounds rotate by two.
    localparam logic [15:0] SHIFT_ONE = 16'b1000_0001_0000_0011;

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      r_state;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [3:0]  r_idx;
    logic        r_mode;
    logic        r_busy;
    logic        r_valid;
    logic        r_done;

    logic [55:0] w_cd0;
    logic [27:0] w_c0;
    logic [27:0] w_d0;
    logic [55:0] w_cd;
    logic [3:0]  w_idx_inc;
    logic [3:0]  w_idx_dec;
    logic        w_two_fwd;
    logic        w_two_rev;
    logic        w_last;
    logic        w_unused_parity;

    always_comb begin
        w_cd0 = '0;
        for (int i = 0; i < 56; i++) begin
            w_cd0[6'(55 - i)] = key[6'(64 - PC1[i])];
        end
    end

    assign w_c0 = w_cd0[55:28];
    assign w_d0 = w_cd0[27:0];
    assign w_cd = {r_c, r_d};

    always_comb begin
        rkey = '0;
        for (int i = 0; i < 48; i++) begin
            rkey[6'(47 - i)] = w_cd[6'(56 - PC2[i])];
        end
    end

    assign w_idx_inc = r_idx + 4'd1;
    assign w_idx_dec = r_idx - 4'd1;
    assign w_two_fwd = ~SHIFT_ONE[w_idx_inc];
    assign w_two_rev = ~SHIFT_ONE[r_idx];
    assign w_last    = r_mode ? (r_idx == 4'd0) : (r_idx == 4'd15);

    assign w_unused_parity = ^{key[56], key[48], key[40], key[32],
                               key[24], key[16], key[8], key[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_c     <= '0;
            r_d     <= '0;
            r_idx   <= '0;
            r_mode  <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode  <= decrypt;
                        r_state <= S_EMIT;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
                        // Total rotation is 28, so C16/D16 equal C0/D0.
                        if (decrypt) begin
                            r_c   <= w_c0;
                            r_d   <= w_d0;
                            r_idx <= 4'd15;
                        end else begin
                            r_c   <= rotl(w_c0, 1'b0);
                            r_d   <= rotl(w_d0, 1'b0);
                            r_idx <= 4'd0;
                        end
                    end
                end
                S_EMIT: begin
                    if (rkey_ready) begin
                        if (w_last) begin
                            r_state <= S_FIN;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (r_mode) begin
                            r_c   <= rotr(r_c, w_two_rev);
                            r_d   <= rotr(r_d, w_two_rev);
                            r_idx <= w_idx_dec;
                        end else begin
                            r_c   <= rotl(r_c, w_two_fwd);
                            r_d   <= rotl(r_d, w_two_fwd);
                            r_idx <= w_idx_inc;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign rkey_valid = r_valid;
    assign rkey_idx   = r_idx;
    assign done       = r_done;

endmodule

// File: tb/tb_des_key_sched_seq.sv
// Bench for des_key_sched_seq: vector table of schedules checked through
// a scoreboard of expected round keys, plus reset and ignored-start sequences.
module tb_des_key_sched_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic [63:0] key = '0;
    logic        rkey_ready = 1'b0;
    logic        busy;
    logic        rkey_valid;
    logic [47:0] rkey;
    logic [3:0]  rkey_idx;
    logic        done;

    des_key_sched_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .decrypt    (decrypt),
        .key        (key),
        .busy       (busy),
        .rkey_valid (rkey_valid),
        .rkey_ready (rkey_ready),
        .rkey       (rkey),
        .rkey_idx   (rkey_idx),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] key;
        logic        dec;
        int          pct;
        int          kind;
    } vec_t;

    typedef struct {
        logic [47:0] k;
        logic [3:0]  idx;
    } exp_t;

    localparam logic [63:0] GKEY = 64'h133457799BBCDFF1;

    logic [47:0] gold [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    exp_t        sbq [$];
    vec_t        vecs [10];
    int          tests = 0;
    int          fails = 0;
    int          pct = 100;
    int          done_cnt = 0;
    int          pops = 0;
    logic        p_stall = 1'b0;
    logic [47:0] p_key = '0;
    logic [3:0]  p_idx = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rkey_ready = (int'($urandom_range(0, 99)) < pct);
        end
    end

    // Monitor: scoreboard pops, stall stability, busy/done relations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (p_stall) begin
                    tests++;
                    if (!rkey_valid || rkey !== p_key || rkey_idx !== p_idx) begin
                        fails++;
                        $display("FAIL stall_hold got v=%b k=%h i=%0d want k=%h i=%0d",
                                 rkey_valid, rkey, rkey_idx, p_key, p_idx);
                    end
                end
                if (rkey_valid) begin
                    tests++;
                    if (busy !== 1'b1) begin
                        fails++;
                        $display("FAIL busy_emit got %b want 1", busy);
                    end
                end
                if (done) begin
                    done_cnt++;
                    tests++;
                    if (rkey_valid !== 1'b0) begin
                        fails++;
                        $display("FAIL done_valid got %b want 0", rkey_valid);
                    end
                end
                if (rkey_valid && rkey_ready) begin
                    tests++;
                    pops++;
                    if (sbq.size() == 0) begin
                        fails++;
                        $display("FAIL sb_extra got k=%h i=%0d want none", rkey, rkey_idx);
                    end else begin
                        e = sbq.pop_front();
                        if (rkey !== e.k || rkey_idx !== e.idx) begin
                            fails++;
                            $display("FAIL sb_key got k=%h i=%0d want k=%h i=%0d",
                                     rkey, rkey_idx, e.k, e.idx);
                        end
                    end
                end
                p_stall = rkey_valid && !rkey_ready;
                p_key   = rkey;
                p_idx   = rkey_idx;
            end else begin
                p_stall = 1'b0;
            end
        end
    end

    task automatic push_exp(input vec_t v);
        exp_t e;
        int   rr;
        for (int r = 0; r < 16; r++) begin
            rr    = v.dec ? 15 - r : r;
            e.idx = 4'(rr);
            if (v.kind == 0) e.k = gold[rr];
            else if (v.kind == 1) e.k = '0;
            else e.k = '1;
            sbq.push_back(e);
        end
    endtask

    task automatic issue(input vec_t v);
        pct = v.pct;
        @(posedge clk);
        #1;
        key     = v.key;
        decrypt = v.dec;
        start   = 1'b1;
        done_cnt = 0;
        push_exp(v);
        @(posedge clk);
        #1;
        start   = 1'b0;
        key     = ~v.key;
        decrypt = ~v.dec;
    endtask

    task automatic run_vec(input vec_t v, input bit inject);
        int lat;
        issue(v);
        lat = 1;
        while (lat < 4000) begin
            @(negedge clk);
            if (done) break;
            #1;
            start = inject && rkey_valid && (rkey_idx == 4'd2 || rkey_idx == 4'd9);
            if (start) key = 64'hFFFFFFFFFFFFFFFF;
            lat++;
        end
        start = 1'b0;
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL done_timeout got %b want 1 after %0d cycles", done, lat);
        end
        if (v.pct == 100) begin
            tests++;
            if (lat != 17) begin
                fails++;
                $display("FAIL done_latency got %0d want 17", lat);
            end
        end
        repeat (2) @(negedge clk);
        tests++;
        if (done_cnt != 1 || busy !== 1'b0 || sbq.size() != 0) begin
            fails++;
            $display("FAIL end_state got done_cnt=%0d busy=%b left=%0d want 1 0 0",
                     done_cnt, busy, sbq.size());
        end
    endtask

    task automatic check_zero(input string nm);
        tests++;
        if (busy !== 1'b0 || rkey_valid !== 1'b0 || done !== 1'b0 ||
            rkey_idx !== 4'd0 || rkey !== 48'd0) begin
            fails++;
            $display("FAIL %s got b=%b v=%b d=%b i=%0d k=%h want all 0",
                     nm, busy, rkey_valid, done, rkey_idx, rkey);
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{GKEY, 1'b0, 100, 0};
        vecs[1] = '{GKEY, 1'b1, 100, 0};
        vecs[2] = '{GKEY, 1'b0, 30, 0};
        vecs[3] = '{GKEY, 1'b1, 30, 0};
        vecs[4] = '{64'h123556789ABDDEF0, 1'b0, 100, 0};
        vecs[5] = '{64'h123556789ABDDEF0, 1'b1, 30, 0};
        vecs[6] = '{64'h0000000000000000, 1'b0, 100, 1};
        vecs[7] = '{64'h0101010101010101, 1'b1, 30, 1};
        vecs[8] = '{64'hFFFFFFFFFFFFFFFF, 1'b1, 100, 2};
        vecs[9] = '{64'hFEFEFEFEFEFEFEFE, 1'b0, 30, 2};

        repeat (3) @(negedge clk);
        check_zero("reset_state");
        #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("idle_state");

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], 1'b0);
        end

        run_vec('{GKEY, 1'b0, 100, 0}, 1'b1);
        run_vec('{GKEY, 1'b1, 100, 0}, 1'b1);

        pops = 0;
        issue('{GKEY, 1'b0, 100, 0});
        n = 0;
        while (pops < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid");
        sbq.delete();
        repeat (2) @(negedge clk);
        check_zero("reset_hold");
        #2;
        rst_n = 1'b1;
        run_vec('{GKEY, 1'b0, 100, 0}, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
